// File: rtl/i2c_fifo_bridge_if.sv
// i2c_fifo_bridge_if: APB-bridge and I2C-engine signals of the dual FIFO
//   master: drives pushes/pops/data/ERR_CLR (APB bridge + I2C engine side)
//   slave : the FIFO block, returns heads, status, levels and error flags
interface i2c_fifo_bridge_if #(
    parameter int DWIDTH = 32,
    parameter int AW     = 4
);
    logic              WR_ENA;
    logic [DWIDTH-1:0] WRITE_DATA_ON_TX;
    logic              RD_ENA;
    logic [DWIDTH-1:0] READ_DATA_ON_RX;
    logic              TX_POP;
    logic [DWIDTH-1:0] TX_DATA;
    logic              RX_PUSH;
    logic [DWIDTH-1:0] RX_DATA;
    logic              TX_EMPTY;
    logic              TX_FULL;
    logic              RX_EMPTY;
    logic              RX_FULL;
    logic [AW:0]       TX_LEVEL;
    logic [AW:0]       RX_LEVEL;
    logic              ERR_CLR;
    logic [3:0]        ERR_FLAGS;
    logic              ERROR;
    modport slave (
        input  WR_ENA, WRITE_DATA_ON_TX, RD_ENA, TX_POP, RX_PUSH, RX_DATA, ERR_CLR,
        output READ_DATA_ON_RX, TX_DATA, TX_EMPTY, TX_FULL, RX_EMPTY, RX_FULL,
               TX_LEVEL, RX_LEVEL, ERR_FLAGS, ERROR
    );
    modport master (
        output WR_ENA, WRITE_DATA_ON_TX, RD_ENA, TX_POP, RX_PUSH, RX_DATA, ERR_CLR,
        input  READ_DATA_ON_RX, TX_DATA, TX_EMPTY, TX_FULL, RX_EMPTY, RX_FULL,
               TX_LEVEL, RX_LEVEL, ERR_FLAGS, ERROR
    );
endinterface

// File: rtl/i2c_fifo_bridge.sv
// i2c_fifo_bridge: TX/RX synchronous FIFOs between APB bridge and I2C engine
//   PCLK/PRESET : clock, synchronous active-high reset
//   bus (slave) : TX push (WR_ENA) / pop (TX_POP), RX push (RX_PUSH) / pop (RD_ENA),
//                 first-word-fall-through heads, levels, empty/full, sticky ERR_FLAGS
module i2c_fifo_bridge_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level,
    output logic              ovf,
    output logic              unf
);
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wp, rp;
    logic              pop_ok, push_ok;
    assign empty   = level == '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign pop_ok  = pop && !empty;
    // a pop on a full FIFO frees the slot the push writes into
    assign push_ok = push && (!full || pop_ok);
    assign ovf     = push && !push_ok;
    assign unf     = pop && !pop_ok;
    assign head    = empty ? '0 : mem[rp];
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok) rp <= rp + 1'b1;
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
    always_ff @(posedge PCLK)
        if (push_ok && !PRESET) mem[wp] <= wdata;
endmodule

module i2c_fifo_bridge #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input logic              PCLK,
    input logic              PRESET,
    i2c_fifo_bridge_if.slave bus
);
    logic tx_ovf, tx_unf, rx_ovf, rx_unf;
    logic [3:0] err_flags;
    i2c_fifo_bridge_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(AW)) u_tx (
        .PCLK(PCLK), .PRESET(PRESET), .push(bus.WR_ENA), .pop(bus.TX_POP),
        .wdata(bus.WRITE_DATA_ON_TX), .head(bus.TX_DATA), .empty(bus.TX_EMPTY),
        .full(bus.TX_FULL), .level(bus.TX_LEVEL), .ovf(tx_ovf), .unf(tx_unf)
    );
    i2c_fifo_bridge_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(AW)) u_rx (
        .PCLK(PCLK), .PRESET(PRESET), .push(bus.RX_PUSH), .pop(bus.RD_ENA),
        .wdata(bus.RX_DATA), .head(bus.READ_DATA_ON_RX), .empty(bus.RX_EMPTY),
        .full(bus.RX_FULL), .level(bus.RX_LEVEL), .ovf(rx_ovf), .unf(rx_unf)
    );
    // a new event in the same cycle as ERR_CLR keeps its flag set
    always_ff @(posedge PCLK)
        err_flags <= PRESET ? 4'b0000
                   : ((bus.ERR_CLR ? 4'b0000 : err_flags) | {rx_unf, rx_ovf, tx_unf, tx_ovf});
    assign bus.ERR_FLAGS = err_flags;
    assign bus.ERROR     = |err_flags;
endmodule

// File: tb/tb_i2c_fifo_bridge.sv
// tb_i2c_fifo_bridge: queue-scoreboard bench for i2c_fifo_bridge
module tb_i2c_fifo_bridge;
    localparam int DW = 32, DEPTH = 16, AW = 4;
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    i2c_fifo_bridge_if #(.DWIDTH(DW), .AW(AW)) bus ();
    i2c_fifo_bridge #(.DWIDTH(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
    );
    always #5 PCLK = ~PCLK;
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic [3:0]  ef = 4'b0000;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic check_state();
        check("tx_level", 32'(bus.TX_LEVEL), txq.size());
        check("rx_level", 32'(bus.RX_LEVEL), rxq.size());
        check("tx_empty", 32'(bus.TX_EMPTY), 32'(txq.size() == 0));
        check("tx_full", 32'(bus.TX_FULL), 32'(txq.size() == DEPTH));
        check("rx_empty", 32'(bus.RX_EMPTY), 32'(rxq.size() == 0));
        check("rx_full", 32'(bus.RX_FULL), 32'(rxq.size() == DEPTH));
        check("err_flags", 32'(bus.ERR_FLAGS), 32'(ef));
        check("error", 32'(bus.ERROR), 32'(|ef));
        check("tx_head", bus.TX_DATA, txq.size() > 0 ? txq[0] : 32'h0);
        check("rx_head", bus.READ_DATA_ON_RX, rxq.size() > 0 ? rxq[0] : 32'h0);
    endtask
    // one clock cycle: drive after a falling edge, score pops, update model, check state after the edge
    task automatic cycle(input logic rs, input logic wr, input logic [31:0] wd, input logic tp,
                         input logic rp, input logic [31:0] rd, input logic re, input logic cl);
        logic tpv, tacc, rpv, racc;
        logic [3:0] ev;
        PRESET = rs;
        bus.WR_ENA = wr; bus.WRITE_DATA_ON_TX = wd; bus.TX_POP = tp;
        bus.RX_PUSH = rp; bus.RX_DATA = rd; bus.RD_ENA = re; bus.ERR_CLR = cl;
        #1;
        if (tp && !rs) check("tx_pop_data", bus.TX_DATA, txq.size() > 0 ? txq[0] : 32'h0);
        if (re && !rs) check("rx_pop_data", bus.READ_DATA_ON_RX, rxq.size() > 0 ? rxq[0] : 32'h0);
        tpv  = tp && txq.size() > 0;
        tacc = wr && (txq.size() < DEPTH || tpv);
        rpv  = re && rxq.size() > 0;
        racc = rp && (rxq.size() < DEPTH || rpv);
        ev   = {re && !rpv, rp && !racc, tp && !tpv, wr && !tacc};
        if (rs) begin
            txq.delete(); rxq.delete(); ef = 4'b0000;
        end else begin
            if (tpv) void'(txq.pop_front());
            if (tacc) txq.push_back(wd);
            if (rpv) void'(rxq.pop_front());
            if (racc) rxq.push_back(rd);
            ef = (cl ? 4'b0000 : ef) | ev;
        end
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        bus.WR_ENA = 1'b0; bus.TX_POP = 1'b0; bus.RX_PUSH = 1'b0; bus.RD_ENA = 1'b0; bus.ERR_CLR = 1'b0;
        check_state();
    endtask
    initial begin
        bus.WR_ENA = 1'b0; bus.WRITE_DATA_ON_TX = '0; bus.TX_POP = 1'b0;
        bus.RX_PUSH = 1'b0; bus.RX_DATA = '0; bus.RD_ENA = 1'b0; bus.ERR_CLR = 1'b0;
        @(negedge PCLK);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // TX fill to full, one overflowing word, then drain in order
        for (int i = 1; i <= 16; i++) cycle(0, 1, 32'hA5A50000 + i, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 0, 0, 0, 0);
        // RX single word, pop, then underflowing pop
        cycle(0, 0, 0, 0, 1, 32'h11, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        // RX full with simultaneous push and pop, then drain
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 1, 32'hB0000000 + i, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'hBEEF0001, 1, 0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);
        // TX streaming at level 1 across several pointer wraps
        cycle(0, 1, 32'hC0000000, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 40; i++) cycle(0, 1, 32'hC0000000 + i, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        // empty push+pop: underflow, push still lands
        cycle(0, 1, 32'h5A5A0001, 1, 1, 32'h6B6B0001, 1, 0);
        cycle(0, 0, 0, 1, 0, 0, 1, 1);
        // clear racing a fresh TX underflow, then clear alone
        cycle(0, 0, 0, 1, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        // reset in the middle of a burst with every input active
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'hE0000000 + i, 0, 1, 32'hF0000000 + i, 0, 0);
        cycle(0, 1, 32'hE0000005, 1, 1, 32'hF0000005, 1, 0);
        cycle(1, 1, 32'hE0000006, 1, 1, 32'hF0000006, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h12345678, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_fifo_bridge.md
Name: i2c_fifo_bridge

Overview:
- Dual synchronous FIFO between the APB slave bridge and the I2C byte/bit engine.
- TX FIFO: written by the APB bridge (WR_ENA, WRITE_DATA_ON_TX) and drained by the I2C engine.
- RX FIFO: filled by the I2C engine and drained by the APB bridge (RD_ENA, READ_DATA_ON_RX).
- Generates the bridge's TX_EMPTY, RX_EMPTY and ERROR inputs, with sticky overflow/underflow tracking.

Parameters:
DWIDTH, 32, data word width for both FIFOs
DEPTH, 16, entries per FIFO; power of two, >= 2
AW, 4, pointer width = log2(DEPTH)

Ports:
PCLK  in  1  single clock, all logic on rising edge
PRESET  in  1  reset, synchronous, active-high
WR_ENA  in  1  APB push into TX FIFO, one word per cycle high
WRITE_DATA_ON_TX  in  DWIDTH  TX push data
RD_ENA  in  1  APB pop from RX FIFO, one word per cycle high
READ_DATA_ON_RX  out  DWIDTH  RX head word (first-word fall-through)
TX_POP  in  1  I2C engine pop from TX FIFO
TX_DATA  out  DWIDTH  TX head word (first-word fall-through)
RX_PUSH  in  1  I2C engine push into RX FIFO
RX_DATA  in  DWIDTH  RX push data
TX_EMPTY  out  1  TX FIFO holds 0 words
TX_FULL  out  1  TX FIFO holds DEPTH words
RX_EMPTY  out  1  RX FIFO holds 0 words
RX_FULL  out  1  RX FIFO holds DEPTH words
TX_LEVEL  out  AW+1  TX occupancy 0..DEPTH
RX_LEVEL  out  AW+1  RX occupancy 0..DEPTH
ERR_CLR  in  1  clears all sticky error flags
ERR_FLAGS  out  4  sticky flags: [0] TX overflow, [1] TX underflow, [2] RX overflow, [3] RX underflow
ERROR  out  1  OR of ERR_FLAGS

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Clock port is PCLK, reset port is PRESET.
- Reset (PRESET=1 at a PCLK edge):
  - All pointers and levels go to 0; ERR_FLAGS=0.
  - TX_EMPTY=RX_EMPTY=1, TX_FULL=RX_FULL=0.
  - Storage contents are don't-care.
  - Reset overrides every concurrent push, pop or clear, including mid-transfer.
- Each FIFO is an independent instance of the same logic, with:
  - a write pointer and a read pointer, each AW bits, wrapping modulo DEPTH;
  - a level counter of AW+1 bits.
  - EMPTY = (level==0) and FULL = (level==DEPTH). Both are registered-state decodes with no combinational path from push or pop inputs.
- Push (TX: WR_ENA; RX: RX_PUSH):
  - Accepted if level<DEPTH, or if a valid pop occurs in the same cycle.
  - When accepted, data is written at the write pointer and the pointer increments.
- Pop (TX: TX_POP; RX: RD_ENA):
  - Valid only if level>0.
  - When valid, the read pointer increments.
- Level update: +1 on push only, -1 on pop only, unchanged on push+pop.
- Empty with simultaneous push and pop:
  - The pop is an underflow; the push is accepted; level becomes 1.
  - The pushed word appears at the head on the next cycle.
- Full with push and no pop: overflow; the word is dropped; pointers and level are unchanged.
- Head output (READ_DATA_ON_RX, TX_DATA):
  - Combinational read of storage at the read pointer when level>0; all-zero when empty.
  - Effect: the APB bridge sees valid PRDATA in the same cycle RD_ENA is high, and the pop takes effect at that edge.
- Write latency: a word pushed at edge N is visible at the head after edge N when the FIFO was empty, and the level increments at edge N.
- Error flags:
  - Each flag sets on its event: [0] TX overflow, [1] TX underflow, [2] RX overflow, [3] RX underflow.
  - Each flag stays set until ERR_CLR is sampled high.
  - ERR_CLR and a new event in the same cycle leave the flag set (event wins).
  - ERROR = |ERR_FLAGS, combinational from the registers.
- Bridge-facing assumption: WR_ENA and RD_ENA pulse for exactly one cycle per APB access phase. The block applies no edge detection; every high cycle counts as one operation.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap. Data order is strictly FIFO across the wrap.

Test Plan:
- Reset then idle -> TX_EMPTY=RX_EMPTY=1, levels 0, ERR_FLAGS=4'b0000, READ_DATA_ON_RX=TX_DATA=32'h0.
- WR_ENA with 0xA5A50001..0xA5A50010 (16 words), then a 17th word 0xDEADBEEF -> TX_FULL=1 after the 16th, TX_LEVEL=16, ERR_FLAGS[0]=1. TX_POP drains 0xA5A50001..0xA5A50010 in order, never 0xDEADBEEF.
- RX_PUSH 0x11 then RD_ENA in the next cycle -> READ_DATA_ON_RX=0x11 during the RD_ENA cycle, then RX_EMPTY=1. A second RD_ENA sets ERR_FLAGS[3]=1, ERROR=1, and READ_DATA_ON_RX=0.
- RX full (16 words) with RX_PUSH=1 and RD_ENA=1 in the same cycle -> RX_LEVEL stays 16, no overflow flag, the head advances, and the new word lands last.
- Push and pop 40 words through TX at one push and one pop per cycle from level 1 -> pointers wrap at least twice, the output sequence equals the input sequence, and TX_LEVEL stays 1.
- ERR_CLR=1 in the same cycle as a TX_POP on an empty FIFO -> ERR_FLAGS[1] stays 1. ERR_CLR alone next cycle -> ERR_FLAGS=0. PRESET asserted mid-burst -> all state returns to reset values on the next edge.
